// File: rtl/gci_std_display_rect_fill_master.sv
// GCI bus master that fills a clipped rectangle of the display bitmap
// with one 16-bit 5R6G5B colour, one write per pixel.
// Ports:
//   iCLOCK/iRESET        clock, async active-high reset
//   iCMD_*/oCMD_BUSY     command input (X, Y, W, H, colour) and busy flag
//   oDONE                one-cycle pulse when a command is fully retired
//   oERR_SPURIOUS        sticky: response seen with nothing outstanding
//   oDEV_*/iDEV_BUSY     write request channel to the display slave
//   iDEV_REQ/iDEV_DATA   slave response pulse (data ignored)
module gci_std_display_rect_fill_master #(
    parameter logic [31:0] BITMAP_BASE = 32'h0000C400,
    parameter int          H_RES       = 640,
    parameter int          V_RES       = 480,
    parameter int          MAX_OUT     = 4
) (
    input  logic        iCLOCK,
    input  logic        iRESET,
    input  logic        iCMD_REQ,
    output logic        oCMD_BUSY,
    input  logic [9:0]  iCMD_X,
    input  logic [9:0]  iCMD_Y,
    input  logic [10:0] iCMD_W,
    input  logic [9:0]  iCMD_H,
    input  logic [15:0] iCMD_COLOR,
    output logic        oDONE,
    output logic        oERR_SPURIOUS,
    output logic        oDEV_REQ,
    input  logic        iDEV_BUSY,
    output logic        oDEV_RW,
    output logic [31:0] oDEV_ADDR,
    output logic [31:0] oDEV_DATA,
    input  logic        iDEV_REQ,
    input  logic [31:0] iDEV_DATA
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_ZERO,
        ST_DONE
    } state_t;

    localparam logic [31:0] LP_STRIDE = 32'(H_RES * 4);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_row_addr;
    logic [15:0] r_color;
    logic [10:0] r_w;
    logic [9:0]  r_h;
    logic [10:0] r_col;
    logic [9:0]  r_row;
    logic [3:0]  r_out;
    logic        r_err;

    logic        w_cmd_acc;
    logic        w_zero;
    logic [10:0] w_wroom;
    logic [9:0]  w_hroom;
    logic [10:0] w_weff;
    logic [9:0]  w_heff;
    logic [31:0] w_start;
    logic        w_req;
    logic        w_acc;
    logic        w_last_col;
    logic        w_last_pix;
    logic        w_unused;

    assign w_unused = ^iDEV_DATA;

    // Clipping against the right and bottom screen edges.
    assign w_wroom = 11'(H_RES) - {1'b0, iCMD_X};
    assign w_hroom = 10'(V_RES) - iCMD_Y;
    assign w_weff  = (iCMD_W < w_wroom) ? iCMD_W : w_wroom;
    assign w_heff  = (iCMD_H < w_hroom) ? iCMD_H : w_hroom;
    assign w_zero  = ({1'b0, iCMD_X} >= 11'(H_RES)) ||
                     (iCMD_Y >= 10'(V_RES)) ||
                     (iCMD_W == 11'd0) || (iCMD_H == 10'd0);
    assign w_start = BITMAP_BASE +
                     ((32'(iCMD_Y) * 32'(H_RES) + 32'(iCMD_X)) << 2);

    assign w_cmd_acc  = (r_state == ST_IDLE) && iCMD_REQ;
    // Request only depends on state and count, so once raised it
    // cannot fall before being accepted (count only drops meanwhile).
    assign w_req      = (r_state == ST_ISSUE) && (r_out < 4'(MAX_OUT));
    assign w_acc      = w_req && !iDEV_BUSY;
    assign w_last_col = (r_col == r_w - 11'd1);
    assign w_last_pix = w_last_col && (r_row == r_h - 10'd1);

    assign oDEV_REQ      = w_req;
    assign oDEV_RW       = w_req;
    assign oDEV_ADDR     = r_addr;
    assign oDEV_DATA     = {16'h0000, r_color};
    assign oERR_SPURIOUS = r_err;
    assign oCMD_BUSY     = (r_state == ST_ISSUE) || (r_state == ST_DRAIN) ||
                           (r_state == ST_ZERO);
    assign oDONE         = (r_state == ST_DONE);

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (iCMD_REQ) begin
                    w_next = w_zero ? ST_ZERO : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_acc && w_last_pix) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_out == 4'd0) begin
                    w_next = ST_DONE;
                end
            end
            ST_ZERO: w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            r_addr     <= 32'd0;
            r_row_addr <= 32'd0;
            r_color    <= 16'd0;
            r_w        <= 11'd0;
            r_h        <= 10'd0;
            r_col      <= 11'd0;
            r_row      <= 10'd0;
        end else if (w_cmd_acc && !w_zero) begin
            r_addr     <= w_start;
            r_row_addr <= w_start;
            r_color    <= iCMD_COLOR;
            r_w        <= w_weff;
            r_h        <= w_heff;
            r_col      <= 11'd0;
            r_row      <= 10'd0;
        end else if (w_acc) begin
            if (w_last_col) begin
                r_col      <= 11'd0;
                r_row      <= r_row + 10'd1;
                r_row_addr <= r_row_addr + LP_STRIDE;
                r_addr     <= r_row_addr + LP_STRIDE;
            end else begin
                r_col  <= r_col + 11'd1;
                r_addr <= r_addr + 32'd4;
            end
        end
    end

    // Outstanding-write counter and spurious-response flag.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            r_out <= 4'd0;
            r_err <= 1'b0;
        end else begin
            if (w_acc && !iDEV_REQ) begin
                r_out <= r_out + 4'd1;
            end else if (!w_acc && iDEV_REQ && (r_out != 4'd0)) begin
                r_out <= r_out - 4'd1;
            end
            if (w_cmd_acc) begin
                r_err <= 1'b0;
            end
            if (!w_acc && iDEV_REQ && (r_out == 4'd0)) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gci_std_display_rect_fill_master.sv
// Directed bench for the rectangle fill master with a small
// slave model (busy injection, delayed or withheld responses).
module tb_gci_std_display_rect_fill_master;

    logic        iCLOCK = 1'b0;
    logic        iRESET = 1'b1;
    logic        iCMD_REQ = 1'b0;
    logic        oCMD_BUSY;
    logic [9:0]  iCMD_X = '0;
    logic [9:0]  iCMD_Y = '0;
    logic [10:0] iCMD_W = '0;
    logic [9:0]  iCMD_H = '0;
    logic [15:0] iCMD_COLOR = '0;
    logic        oDONE;
    logic        oERR_SPURIOUS;
    logic        oDEV_REQ;
    logic        iDEV_BUSY = 1'b0;
    logic        oDEV_RW;
    logic [31:0] oDEV_ADDR;
    logic [31:0] oDEV_DATA;
    logic        iDEV_REQ = 1'b0;
    logic [31:0] iDEV_DATA = 32'h0;

    gci_std_display_rect_fill_master dut (
        .iCLOCK        (iCLOCK),
        .iRESET        (iRESET),
        .iCMD_REQ      (iCMD_REQ),
        .oCMD_BUSY     (oCMD_BUSY),
        .iCMD_X        (iCMD_X),
        .iCMD_Y        (iCMD_Y),
        .iCMD_W        (iCMD_W),
        .iCMD_H        (iCMD_H),
        .iCMD_COLOR    (iCMD_COLOR),
        .oDONE         (oDONE),
        .oERR_SPURIOUS (oERR_SPURIOUS),
        .oDEV_REQ      (oDEV_REQ),
        .iDEV_BUSY     (iDEV_BUSY),
        .oDEV_RW       (oDEV_RW),
        .oDEV_ADDR     (oDEV_ADDR),
        .oDEV_DATA     (oDEV_DATA),
        .iDEV_REQ      (iDEV_REQ),
        .iDEV_DATA     (iDEV_DATA)
    );

    always #5 iCLOCK = ~iCLOCK;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [31:0] wa[$];
    logic [31:0] wd[$];
    int          due[$];
    int  n_acc = 0;
    int  outst = 0;
    int  max_out = 0;
    int  done_cnt = 0;
    int  done_cyc = 0;
    int  last_resp_cyc = 0;
    int  req_cnt = 0;
    int  watch_cnt = 0;
    logic [31:0] watch_addr = 32'hFFFF_FFFF;
    int  stab_err = 0;
    int  rw_err = 0;
    int  busy_at = -1;
    int  busy_left = 0;
    bit  busy_fired = 0;
    bit  hold = 0;
    bit  spur_req = 0;
    bit  prev_pend = 0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_data = '0;
    int  cmd_cyc = 0;

    always @(posedge iCLOCK) cyc <= cyc + 1;

    // Slave model and monitors, evaluated away from the active edge.
    always @(negedge iCLOCK) begin
        logic acc;
        if (oDONE) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (oDEV_REQ) req_cnt++;
        if (oDEV_REQ && oDEV_ADDR == watch_addr) watch_cnt++;
        if (prev_pend && !iRESET &&
            (!oDEV_REQ || oDEV_ADDR != prev_addr ||
             oDEV_DATA != prev_data))
            stab_err++;
        if (iRESET) begin
            due.delete();
            outst = 0;
        end
        iDEV_REQ = spur_req;
        if (!hold && due.size() > 0 && due[0] <= cyc) begin
            void'(due.pop_front());
            iDEV_REQ = 1'b1;
            outst--;
            last_resp_cyc = cyc;
        end
        if (oDEV_REQ && n_acc == busy_at && !busy_fired) begin
            busy_fired = 1;
            busy_left = 3;
        end
        iDEV_BUSY = (busy_left > 0);
        if (busy_left > 0) busy_left--;
        acc = oDEV_REQ && !iDEV_BUSY;
        if (acc) begin
            wa.push_back(oDEV_ADDR);
            wd.push_back(oDEV_DATA);
            n_acc++;
            outst++;
            if (outst > max_out) max_out = outst;
            due.push_back(cyc + 1);
            if (!oDEV_RW) rw_err++;
        end
        prev_pend = oDEV_REQ && iDEV_BUSY;
        prev_addr = oDEV_ADDR;
        prev_data = oDEV_DATA;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr();
        wa.delete();
        wd.delete();
        n_acc = 0;
        max_out = 0;
        req_cnt = 0;
        watch_cnt = 0;
        busy_at = -1;
        busy_fired = 0;
    endtask

    task automatic run_cmd(input int x, input int y, input int w,
                           input int h, input logic [15:0] c);
        @(negedge iCLOCK);
        #1;
        iCMD_X = 10'(x);
        iCMD_Y = 10'(y);
        iCMD_W = 11'(w);
        iCMD_H = 10'(h);
        iCMD_COLOR = c;
        iCMD_REQ = 1'b1;
        cmd_cyc = cyc;
        @(negedge iCLOCK);
        #1;
        iCMD_REQ = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int d0 = done_cnt;
        int t = 0;
        while (done_cnt == d0 && t < 300) begin
            @(negedge iCLOCK);
            #1;
            t++;
        end
        chk(tag, (done_cnt == d0) ? 32'd0 : 32'd1, 32'd1);
    endtask

    initial begin
        logic [31:0] e0;
        int d0;
        int t;

        #2;
        chk("rst_req", {31'b0, oDEV_REQ}, 0);
        chk("rst_busy", {31'b0, oCMD_BUSY}, 0);
        chk("rst_done", {31'b0, oDONE}, 0);
        chk("rst_addr", oDEV_ADDR, 0);
        chk("rst_err", {31'b0, oERR_SPURIOUS}, 0);
        repeat (3) @(negedge iCLOCK);
        #1 iRESET = 1'b0;

        // 1: plain 3x2 fill
        clr();
        d0 = done_cnt;
        run_cmd(0, 0, 3, 2, 16'hF800);
        chk("t1_busy", {31'b0, oCMD_BUSY}, 1);
        wait_done("t1_done");
        repeat (3) @(negedge iCLOCK);
        chk("t1_ndone", done_cnt - d0, 1);
        chk("t1_n", n_acc, 6);
        if (wa.size() == 6) begin
            chk("t1_a0", wa[0], 32'h0000C400);
            chk("t1_a1", wa[1], 32'h0000C404);
            chk("t1_a2", wa[2], 32'h0000C408);
            chk("t1_a3", wa[3], 32'h0000CE00);
            chk("t1_a4", wa[4], 32'h0000CE04);
            chk("t1_a5", wa[5], 32'h0000CE08);
            chk("t1_d5", wd[5], 32'h0000F800);
        end
        chk("t1_d0", (wd.size() > 0) ? wd[0] : 32'hX, 32'h0000F800);

        // 2: busy for 3 cycles on the 2nd write
        clr();
        busy_at = 1;
        watch_addr = 32'h0000C404;
        run_cmd(0, 0, 3, 2, 16'hF800);
        wait_done("t2_done");
        chk("t2_hold", watch_cnt, 4);
        chk("t2_n", n_acc, 6);
        chk("t2_a1", (wa.size() > 1) ? wa[1] : 32'hX, 32'h0000C404);
        chk("t2_a2", (wa.size() > 2) ? wa[2] : 32'hX, 32'h0000C408);
        watch_addr = 32'hFFFF_FFFF;

        // 3: clipping at the bottom-right corner
        clr();
        e0 = 32'h0000C400 + (479 * 640 + 638) * 4;
        run_cmd(638, 479, 10, 10, 16'h07E0);
        wait_done("t3_done");
        chk("t3_n", n_acc, 2);
        chk("t3_a0", (wa.size() > 0) ? wa[0] : 32'hX, e0);
        chk("t3_a1", (wa.size() > 1) ? wa[1] : 32'hX, e0 + 4);
        chk("t3_d0", (wd.size() > 0) ? wd[0] : 32'hX, 32'h000007E0);

        // 4: responses withheld, outstanding limit
        clr();
        hold = 1;
        d0 = done_cnt;
        run_cmd(0, 0, 6, 1, 16'h001F);
        repeat (12) @(negedge iCLOCK);
        #1;
        chk("t4_acc4", n_acc, 4);
        chk("t4_reqlo", {31'b0, oDEV_REQ}, 0);
        chk("t4_nodone", done_cnt - d0, 0);
        hold = 0;
        wait_done("t4_done");
        chk("t4_n", n_acc, 6);
        chk("t4_max", max_out, 4);
        chk("t4_order", (done_cyc > last_resp_cyc) ? 1 : 0, 1);
        chk("t4_a5", (wa.size() > 5) ? wa[5] : 32'hX, 32'h0000C414);

        // 5: zero-area commands and spurious response
        clr();
        run_cmd(0, 0, 0, 4, 16'hFFFF);
        chk("t5_busy", {31'b0, oCMD_BUSY}, 1);
        wait_done("t5a_done");
        chk("t5a_lat", done_cyc - cmd_cyc, 2);
        run_cmd(700, 0, 4, 4, 16'hFFFF);
        wait_done("t5b_done");
        chk("t5b_lat", done_cyc - cmd_cyc, 2);
        chk("t5_noreq", req_cnt, 0);
        @(negedge iCLOCK);
        #1 spur_req = 1;
        @(negedge iCLOCK);
        #1 spur_req = 0;
        repeat (3) @(negedge iCLOCK);
        #1;
        chk("t5_err", {31'b0, oERR_SPURIOUS}, 1);
        run_cmd(0, 0, 0, 1, 16'h0000);
        chk("t5_errclr", {31'b0, oERR_SPURIOUS}, 0);
        wait_done("t5c_done");

        // 6: reset during issue
        clr();
        run_cmd(0, 0, 20, 1, 16'hAAAA);
        t = 0;
        while (n_acc < 3 && t < 50) begin
            @(negedge iCLOCK);
            #1;
            t++;
        end
        chk("t6_started", (n_acc >= 3) ? 1 : 0, 1);
        d0 = done_cnt;
        iRESET = 1'b1;
        #1;
        chk("t6_req", {31'b0, oDEV_REQ}, 0);
        chk("t6_busy", {31'b0, oCMD_BUSY}, 0);
        chk("t6_addr", oDEV_ADDR, 0);
        chk("t6_data", oDEV_DATA, 0);
        repeat (3) @(negedge iCLOCK);
        #1 iRESET = 1'b0;
        repeat (3) @(negedge iCLOCK);
        chk("t6_nodone", done_cnt - d0, 0);
        clr();
        run_cmd(1, 1, 2, 1, 16'h1234);
        wait_done("t6_done");
        chk("t6_n", n_acc, 2);
        chk("t6_a0", (wa.size() > 0) ? wa[0] : 32'hX, 32'h0000CE04);
        chk("t6_a1", (wa.size() > 1) ? wa[1] : 32'hX, 32'h0000CE08);

        chk("stable", stab_err, 0);
        chk("rw", rw_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
